// File: rtl/jtframe_sdram_pkg.sv
// Shared types for the SDRAM bank-side arbitration logic.
package jtframe_sdram_pkg;

  localparam int SDRAM_DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_st_t;

endpackage

// File: rtl/jtframe_rr_pick.sv
// Round-robin picker: first asserted request at or after i_ptr, wrapping at N.
module jtframe_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [PW-1:0] o_gnt_idx,
  output logic          o_any
);

  logic [PW:0] w_idx;

  // Rotation is done with one conditional subtract since i_ptr < N and k < N.
  always_comb begin
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_idx     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(N)) w_idx = w_idx - (PW+1)'(N);
      if (!o_any && i_req[w_idx[PW-1:0]]) begin
        o_any     = 1'b1;
        o_gnt_idx = w_idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/jtframe_bank_slot_arb.sv
// Shares one SDRAM bank read port among SLOTS ROM clients, each with a one-word cache.
module jtframe_bank_slot_arb
  import jtframe_sdram_pkg::*;
#(
  parameter int SLOTS  = 4,
  parameter int AW     = 22,
  parameter int SDRAMW = 23,
  parameter int DW     = SDRAM_DW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dwnld,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic [SDRAMW-1:0]   ba_addr,
  output logic                ba_rd,
  input  logic                ba_ack,
  input  logic                ba_rdy,
  input  logic [DW-1:0]       sdram_dout
);

  localparam int SW = $clog2(SLOTS);

  arb_st_t           r_st, w_st_nxt;
  logic [SW-1:0]     r_sel, r_rr, w_gnt;
  logic [AW-1:0]     r_addr_l;
  logic              r_ba_rd;
  logic [SDRAMW-1:0] r_ba_addr;
  logic              w_any, w_start, w_ack, w_fill;
  logic [SLOTS-1:0]  w_hit, w_miss;
  logic [AW-1:0]     w_addr [SLOTS];

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    logic          r_valid;
    logic [AW-1:0] r_tag;
    logic [DW-1:0] r_dout;
    logic          w_mine;

    assign w_addr[i] = slot_addr[i*AW +: AW];
    assign w_mine    = w_fill && (r_sel == SW'(i));
    // ok tracks the live address, so a fill for an abandoned address never flags ok
    assign w_hit[i]  = slot_cs[i] & r_valid & (w_addr[i] == r_tag);
    assign slot_dout[i*DW +: DW] = r_dout;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_tag   <= '0;
        r_dout  <= '0;
      end else begin
        if (w_mine) begin
          r_tag  <= r_addr_l;
          r_dout <= sdram_dout;
        end
        if (dwnld)       r_valid <= 1'b0;
        else if (w_mine) r_valid <= 1'b1;
      end
    end
  end

  assign w_miss    = slot_cs & ~w_hit;
  assign slot_ok   = w_hit;
  assign ba_rd     = r_ba_rd;
  assign ba_addr   = r_ba_addr;

  jtframe_rr_pick #(
    .N  (SLOTS),
    .PW (SW)
  ) u_pick (
    .i_req     (w_miss),
    .i_ptr     (r_rr),
    .o_gnt_idx (w_gnt),
    .o_any     (w_any)
  );

  // ack and rdy in the same REQ cycle complete the transfer immediately
  always_comb begin
    w_st_nxt = r_st;
    w_start  = 1'b0;
    w_ack    = 1'b0;
    w_fill   = 1'b0;
    case (r_st)
      IDLE: begin
        if (!dwnld && w_any) begin
          w_start  = 1'b1;
          w_st_nxt = REQ;
        end
      end
      REQ: begin
        if (ba_ack) begin
          w_ack = 1'b1;
          if (ba_rdy) begin
            w_fill   = 1'b1;
            w_st_nxt = IDLE;
          end else begin
            w_st_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (ba_rdy) begin
          w_fill   = 1'b1;
          w_st_nxt = IDLE;
        end
      end
      default: w_st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st      <= IDLE;
      r_sel     <= '0;
      r_rr      <= '0;
      r_addr_l  <= '0;
      r_ba_rd   <= 1'b0;
      r_ba_addr <= '0;
    end else begin
      r_st <= w_st_nxt;
      if (w_start) begin
        r_sel     <= w_gnt;
        r_addr_l  <= w_addr[w_gnt];
        r_ba_rd   <= 1'b1;
        r_ba_addr <= SDRAMW'(w_addr[w_gnt]);
      end
      if (w_ack) r_ba_rd <= 1'b0;
      if (w_fill) r_rr <= (r_sel == SW'(SLOTS-1)) ? '0 : r_sel + 1'b1;
    end
  end

endmodule
